reg16_read_port: RTL

Dual-read, single-write 16-bit register file for the 16-bit datapath; it is the consumer side of the existing 16-bit write-enabled register. Each of its registers is loaded through a Write-gated port. Two independent read ports return register contents one cycle after a Read strobe. Read data bypasses a same-cycle write and register 0 is hardwired to zero. It sits between instruction decode (addresses) and the ALU operand latches.

---
 rtl/reg16_pkg.sv | 19 +
 rtl/reg16_read_port_if.sv | 25 ++
 rtl/reg16_read_port_bypass_sel.sv | 24 ++
 rtl/reg16_read_port.sv | 72 +++++++
 4 files changed

// File: rtl/reg16_pkg.sv
// Shared types and constants for the 16-bit dual-read register file.
package reg16_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned AW       = 4;
  localparam int unsigned NREGS    = 2 ** AW;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [AW-1:0]    addr_t;
  typedef data_t [NREGS-1:0] regs_t;

  localparam data_t RESET_DATA = 16'h0000;

  function automatic logic is_zero_reg(input addr_t a);
    return a == addr_t'(ZERO_REG);
  endfunction

endpackage

// File: rtl/reg16_read_port_if.sv
// Write/read bus of the register file; signal names match the original port list.
interface reg16_read_port_if;
  import reg16_pkg::*;

  logic  Write;
  addr_t WAddr;
  data_t I;
  logic  Read;
  addr_t RAddrA;
  addr_t RAddrB;
  data_t OA;
  data_t OB;
  logic  Valid;

  modport master (
    output Write, WAddr, I, Read, RAddrA, RAddrB,
    input  OA, OB, Valid
  );

  modport slave (
    input  Write, WAddr, I, Read, RAddrA, RAddrB,
    output OA, OB, Valid
  );

endinterface

// File: rtl/reg16_read_port_bypass_sel.sv
// Per-port read value select: zero register, then same-edge write bypass, then storage.
module regfile_bypass_sel
  import reg16_pkg::*;
(
  input  addr_t i_raddr,
  input  logic  i_write,
  input  addr_t i_waddr,
  input  data_t i_wdata,
  input  regs_t i_mem,
  output data_t o_value
);

  always_comb begin
    o_value = RESET_DATA;
    if (is_zero_reg(i_raddr)) begin
      o_value = RESET_DATA;
    end else if (i_write && (i_waddr == i_raddr)) begin
      o_value = i_wdata;
    end else begin
      o_value = i_mem[i_raddr];
    end
  end

endmodule

// File: rtl/reg16_read_port.sv
// Dual-read, single-write register file with registered read data and write-first bypass.
module reg16_read_port
  import reg16_pkg::*;
(
  input logic                 CLK,
  input logic                 Reset_n,
  reg16_read_port_if.slave    bus
);

  data_t r_mem [1:NREGS-1];
  data_t r_oa;
  data_t r_ob;
  logic  r_valid;

  regs_t w_mem;
  data_t w_val_a;
  data_t w_val_b;

  // Entry 0 has no flops; it is presented as a constant zero to the selectors.
  always_comb begin
    w_mem    = '0;
    w_mem[0] = RESET_DATA;
    for (int unsigned k = 1; k < NREGS; k++) begin
      w_mem[k] = r_mem[k];
    end
  end

  regfile_bypass_sel u_sel_a (
    .i_raddr (bus.RAddrA),
    .i_write (bus.Write),
    .i_waddr (bus.WAddr),
    .i_wdata (bus.I),
    .i_mem   (w_mem),
    .o_value (w_val_a)
  );

  regfile_bypass_sel u_sel_b (
    .i_raddr (bus.RAddrB),
    .i_write (bus.Write),
    .i_waddr (bus.WAddr),
    .i_wdata (bus.I),
    .i_mem   (w_mem),
    .o_value (w_val_b)
  );

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      for (int unsigned k = 1; k < NREGS; k++) begin
        r_mem[k] <= RESET_DATA;
      end
      r_oa    <= RESET_DATA;
      r_ob    <= RESET_DATA;
      r_valid <= 1'b0;
    end else begin
      for (int unsigned k = 1; k < NREGS; k++) begin
        if (bus.Write && (bus.WAddr == addr_t'(k))) begin
          r_mem[k] <= bus.I;
        end
      end
      if (bus.Read) begin
        r_oa <= w_val_a;
        r_ob <= w_val_b;
      end
      r_valid <= bus.Read;
    end
  end

  assign bus.OA    = r_oa;
  assign bus.OB    = r_ob;
  assign bus.Valid = r_valid;

endmodule
